// File: rtl/sandbox_bench_sequencer.sv
// Host-driven benchmark sequencer: launches one channel, times it, reports status/count.
// Latency: IDLE->REPORT 1-3 cycles plus run time; host handshake held in HOLD until dataReceived drops.
module sandbox_bench_sequencer #(
   parameter int N_CH        = 4,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT_DEF = 1_000_000,
   parameter int IND_CYCLES  = 5_000_000
) (
   input  logic            masterClock,
   input  logic            reset,
   input  logic            dataReceived,
   input  logic [7:0]      control,
   input  logic [31:0]     inputData,
   output logic            clearDR,
   output logic            transmitData,
   output logic [7:0]      status,
   output logic [31:0]     outputData,
   output logic            rxIndicator,
   output logic [N_CH-1:0] doRun,
   input  logic [N_CH-1:0] isRunning,
   input  logic [N_CH-1:0] wasSuccessful
);

   localparam int IND_W = $clog2(IND_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, REPORT, TX, HOLD} state_t;

   state_t           state_q, state_d;
   logic [2:0]       ch_q, ch_d;
   logic [31:0]      limit_q, limit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             seen_q, seen_d;
   logic             dorun_q, dorun_d;
   logic [7:0]       rep_st_q, rep_st_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [7:0]       st_q, st_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             txd_q, txd_d;
   logic             clr_q, clr_d;
   logic [IND_W-1:0] ind_q, ind_d;
   logic [7:0]       last_st_q [N_CH];
   logic [7:0]       last_st_d [N_CH];
   logic [CNT_W-1:0] last_cnt_q [N_CH];
   logic [CNT_W-1:0] last_cnt_d [N_CH];

   logic             ir, ws, fin;
   logic [7:0]       fin_st;
   logic             unused_bits;

   assign unused_bits = ^{control[7:4], inputData};

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      limit_d    = limit_q;
      cnt_d      = cnt_q;
      sat_d      = sat_q;
      seen_d     = seen_q;
      dorun_d    = dorun_q;
      rep_st_d   = rep_st_q;
      rep_cnt_d  = rep_cnt_q;
      st_d       = st_q;
      out_cnt_d  = out_cnt_q;
      txd_d      = txd_q;
      clr_d      = clr_q;
      ind_d      = (ind_q != '0) ? ind_q - 1'b1 : ind_q;
      last_st_d  = last_st_q;
      last_cnt_d = last_cnt_q;
      fin        = 1'b0;
      fin_st     = 8'h00;
      ir         = 1'b0;
      ws         = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_q == 3'(i)) begin
            ir = isRunning[i];
            ws = wasSuccessful[i];
         end
      end

      case (state_q)
         IDLE: begin
            if (dataReceived) begin
               ch_d    = control[3:1];
               limit_d = (inputData[CNT_W-1:0] == '0) ? 32'(TIMEOUT_DEF)
                                                     : 32'(inputData[CNT_W-1:0]);
               ind_d   = IND_W'(IND_CYCLES);
               if (32'(control[3:1]) >= 32'(N_CH)) begin
                  rep_st_d  = {1'b0, control[3:1], 4'b0100};
                  rep_cnt_d = '0;
                  state_d   = REPORT;
               end else if (control[0]) begin
                  state_d = LAUNCH;
               end else begin
                  rep_st_d  = 8'h00;
                  rep_cnt_d = '0;
                  for (int i = 0; i < N_CH; i++) begin
                     if (control[3:1] == 3'(i)) begin
                        rep_st_d  = last_st_q[i];
                        rep_cnt_d = last_cnt_q[i];
                     end
                  end
                  state_d = REPORT;
               end
            end
         end
         LAUNCH: begin
            dorun_d = 1'b1;
            cnt_d   = '0;
            sat_d   = 1'b0;
            seen_d  = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            // completion is checked first so it wins over a coincident timeout
            if (seen_q && !ir) begin
               fin    = 1'b1;
               fin_st = {sat_q, ch_q, 3'b100, ws};
            end else if (32'(cnt_q) == limit_q) begin
               fin    = 1'b1;
               fin_st = {sat_q, ch_q, 4'b1010};
            end else begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               else             sat_d = 1'b1;
               if (ir) begin
                  seen_d  = 1'b1;
                  dorun_d = 1'b0;
               end
            end
            if (fin) begin
               dorun_d   = 1'b0;
               rep_st_d  = fin_st;
               rep_cnt_d = cnt_q;
               for (int i = 0; i < N_CH; i++) begin
                  if (ch_q == 3'(i)) begin
                     last_st_d[i]  = fin_st;
                     last_cnt_d[i] = cnt_q;
                  end
               end
               state_d = REPORT;
            end
         end
         REPORT: begin
            st_d      = rep_st_q;
            out_cnt_d = rep_cnt_q;
            txd_d     = 1'b1;
            state_d   = TX;
         end
         TX: begin
            clr_d   = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (!dataReceived) begin
               txd_d   = 1'b0;
               clr_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge masterClock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         limit_q   <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         seen_q    <= 1'b0;
         dorun_q   <= 1'b0;
         rep_st_q  <= '0;
         rep_cnt_q <= '0;
         st_q      <= '0;
         out_cnt_q <= '0;
         txd_q     <= 1'b0;
         clr_q     <= 1'b0;
         ind_q     <= '0;
         for (int i = 0; i < N_CH; i++) begin
            last_st_q[i]  <= '0;
            last_cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         limit_q    <= limit_d;
         cnt_q      <= cnt_d;
         sat_q      <= sat_d;
         seen_q     <= seen_d;
         dorun_q    <= dorun_d;
         rep_st_q   <= rep_st_d;
         rep_cnt_q  <= rep_cnt_d;
         st_q       <= st_d;
         out_cnt_q  <= out_cnt_d;
         txd_q      <= txd_d;
         clr_q      <= clr_d;
         ind_q      <= ind_d;
         last_st_q  <= last_st_d;
         last_cnt_q <= last_cnt_d;
      end
   end

   always_comb begin
      doRun = '0;
      for (int i = 0; i < N_CH; i++) begin
         doRun[i] = dorun_q && (ch_q == 3'(i));
      end
   end

   assign clearDR      = clr_q;
   assign transmitData = txd_q;
   assign status       = st_q;
   assign outputData   = 32'(out_cnt_q);
   assign rxIndicator  = (ind_q != '0);

endmodule

// File: tb/tb_sandbox_bench_sequencer.sv
// Directed bench for sandbox_bench_sequencer with a channel model and a result scoreboard.
module tb_sandbox_bench_sequencer;

   localparam int N_CH = 4;
   localparam int IND  = 40;

   logic            clk = 1'b0;
   logic            reset;
   logic            dataReceived;
   logic [7:0]      control;
   logic [31:0]     inputData;
   logic            clearDR, transmitData, rxIndicator;
   logic [7:0]      status;
   logic [31:0]     outputData;
   logic [N_CH-1:0] doRun, isRunning, wasSuccessful;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic [39:0] exp_q[$];

   int   m_ch = 0;
   int   m_hold = 0;
   logic m_ws = 1'b0;
   logic m_en = 1'b0;
   logic m_stop = 1'b0;
   logic m_active;
   int   m_cnt;
   logic [N_CH-1:0] m_mask;
   int   dr_hi = 0;
   int   dr_other = 0;

   sandbox_bench_sequencer #(
      .N_CH(N_CH), .CNT_W(8), .TIMEOUT_DEF(1000), .IND_CYCLES(IND)
   ) dut (
      .masterClock(clk), .reset(reset), .dataReceived(dataReceived),
      .control(control), .inputData(inputData), .clearDR(clearDR),
      .transmitData(transmitData), .status(status), .outputData(outputData),
      .rxIndicator(rxIndicator), .doRun(doRun), .isRunning(isRunning),
      .wasSuccessful(wasSuccessful)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // channel model: raises isRunning at the first negedge it sees doRun, holds m_hold negedges
   initial begin
      isRunning = '0;
      wasSuccessful = '0;
      m_active = 1'b0;
      m_cnt = 0;
      forever begin
         @(negedge clk);
         m_mask = '0;
         m_mask[m_ch] = 1'b1;
         if (doRun != '0) dr_hi++;
         if ((doRun & ~m_mask) != '0) dr_other++;
         if (m_active) begin
            m_cnt++;
            if (m_stop || (m_hold != 0 && m_cnt == m_hold)) begin
               isRunning = '0;
               m_active = 1'b0;
            end
         end else if (m_en && doRun[m_ch]) begin
            isRunning = '0;
            isRunning[m_ch] = 1'b1;
            wasSuccessful = '0;
            wasSuccessful[m_ch] = m_ws;
            m_active = 1'b1;
            m_cnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] c, input logic [31:0] d,
                       input logic [7:0] es, input logic [31:0] ed, input int budget);
      logic [39:0] e;
      int n;
      exp_q.push_back({es, ed});
      @(negedge clk);
      control = c;
      inputData = d;
      dataReceived = 1'b1;
      @(negedge clk);
      acc_cyc = cyc;
      check("rx_ind_on", 32'(rxIndicator), 32'd1);
      n = 0;
      while (transmitData !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      e = exp_q.pop_front();
      check("tx_seen", 32'(transmitData), 32'd1);
      check("clr_before_tx", 32'(clearDR), 32'd0);
      check("status", 32'(status), 32'(e[39:32]));
      check("data", outputData, e[31:0]);
      n = 0;
      while (clearDR !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("clr_seen", 32'(clearDR), 32'd1);
      check("tx_hold", 32'(transmitData), 32'd1);
      dataReceived = 1'b0;
      @(negedge clk);
      check("tx_drop", 32'(transmitData), 32'd0);
      check("clr_drop", 32'(clearDR), 32'd0);
      check("status_stable", 32'(status), 32'(e[39:32]));
   endtask

   initial begin
      int base_hi, base_ot, n;
      reset = 1'b0;
      dataReceived = 1'b0;
      control = '0;
      inputData = '0;
      #1;
      check("rst_status", 32'(status), 32'd0);
      check("rst_data", outputData, 32'd0);
      check("rst_tx", 32'(transmitData), 32'd0);
      check("rst_clr", 32'(clearDR), 32'd0);
      check("rst_ind", 32'(rxIndicator), 32'd0);
      check("rst_dorun", 32'(doRun), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // stored result of an unused channel reads as zero
      send(8'h00, 32'd0, 8'h00, 32'd0, 20);

      // ch2 run: isRunning high 10 cycles -> count 10, success
      m_ch = 2; m_hold = 10; m_ws = 1'b1; m_en = 1'b1;
      base_hi = dr_hi; base_ot = dr_other;
      send(8'h05, 32'd100, 8'h29, 32'd10, 60);
      check("run2_dorun_len", 32'(dr_hi - base_hi), 32'd1);
      check("run2_dorun_other", 32'(dr_other - base_ot), 32'd0);
      m_en = 1'b0;

      // ch1 stuck busy -> timeout at 50
      m_ch = 1; m_hold = 0; m_ws = 1'b1; m_en = 1'b1;
      base_hi = dr_hi; base_ot = dr_other;
      send(8'h03, 32'd50, 8'h1A, 32'd50, 100);
      check("tmo_dorun_len", 32'(dr_hi - base_hi), 32'd1);
      check("tmo_dorun_other", 32'(dr_other - base_ot), 32'd0);
      check("tmo_dorun_now", 32'(doRun), 32'd0);
      m_stop = 1'b1; m_en = 1'b0;
      repeat (2) @(negedge clk);
      m_stop = 1'b0;

      // query ch2, bad channel, query ch1 (indicator restarted by the last acceptance)
      base_hi = dr_hi;
      send(8'h04, 32'd0, 8'h29, 32'd10, 20);
      send(8'h0F, 32'd0, 8'h74, 32'd0, 20);
      send(8'h02, 32'd0, 8'h1A, 32'd50, 20);
      check("query_dorun", 32'(dr_hi - base_hi), 32'd0);
      n = 0;
      while (rxIndicator === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("ind_len", 32'(cyc - acc_cyc), 32'(IND));

      // ch3 long run with default timeout -> 8-bit counter saturates
      m_ch = 3; m_hold = 300; m_ws = 1'b1; m_en = 1'b1;
      send(8'h07, 32'd0, 8'hB9, 32'hFF, 400);
      m_en = 1'b0;

      // reset mid-run
      m_ch = 0; m_hold = 0; m_ws = 1'b1; m_en = 1'b1;
      @(negedge clk);
      control = 8'h01;
      inputData = 32'd200;
      dataReceived = 1'b1;
      n = 0;
      while (doRun[0] !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("mid_dorun_seen", 32'(doRun[0]), 32'd1);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("arst_dorun", 32'(doRun), 32'd0);
      check("arst_tx", 32'(transmitData), 32'd0);
      check("arst_clr", 32'(clearDR), 32'd0);
      check("arst_ind", 32'(rxIndicator), 32'd0);
      check("arst_status", 32'(status), 32'd0);
      check("arst_data", outputData, 32'd0);
      m_stop = 1'b1; m_en = 1'b0;
      dataReceived = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      m_stop = 1'b0;

      // stored results were cleared; then a failing ch0 run behaves normally
      send(8'h04, 32'd0, 8'h00, 32'd0, 20);
      m_ch = 0; m_hold = 5; m_ws = 1'b0; m_en = 1'b1;
      send(8'h01, 32'd100, 8'h08, 32'd5, 60);
      m_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
